// File: rtl/div_iter_unit_pkg.sv
// Shared encodings for the iterative divider: FSM states and HI/LO write-enable codes.
package div_iter_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_e;

  localparam logic [1:0] HILO_NONE = 2'b00;
  localparam logic [1:0] HILO_BOTH = 2'b11;

endpackage

// File: rtl/div_iter_unit_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] trial;

  assign trial = {rem_i, quo_i[WIDTH-1]} - {1'b0, dvs_i};

  always_comb begin
    rem_o = {rem_i[WIDTH-2:0], quo_i[WIDTH-1]};
    quo_o = {quo_i[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle DIV/DIVU unit with EX-stage stall and HI/LO write-enable generation.
// Optional macro DIV_ZERO_FAST_EN: divide by zero completes in one cycle.
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_valid_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             flush_i,
  input  logic             hold_i,
  input  logic [1:0]       hilowrite_i,
  output logic             stall_o,
  output logic             result_valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [1:0]       hilowrite_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             qneg_q, rneg_q;
  logic             qneg_in, rneg_in;
  logic             accept;

  assign accept  = (state == IDLE) && div_valid_i && !flush_i;
  assign mag_a   = (signed_i && opa_i[WIDTH-1]) ? -opa_i : opa_i;
  assign mag_b   = (signed_i && opb_i[WIDTH-1]) ? -opb_i : opb_i;
  assign qneg_in = signed_i && (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
  assign rneg_in = signed_i && opa_i[WIDTH-1];

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_nx),
    .quo_o (quo_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    stall_o     = 1'b0;
    hilowrite_o = hilowrite_i;
    case (state)
      IDLE: begin
        if (accept) begin
          stall_o     = 1'b1;
          hilowrite_o = HILO_NONE;
`ifdef DIV_ZERO_FAST_EN
          state_nx    = (opb_i == '0) ? DONE : BUSY;
`else
          state_nx    = BUSY;
`endif
        end
      end
      BUSY: begin
        stall_o     = 1'b1;
        hilowrite_o = HILO_NONE;
        if (flush_i)                  state_nx = IDLE;
        else if (cnt == CNT_W'(1))    state_nx = DONE;
      end
      DONE: begin
        if (flush_i) begin
          hilowrite_o = HILO_NONE;
          state_nx    = IDLE;
        end else begin
          hilowrite_o = HILO_BOTH;
          if (!hold_i) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Sign fix-up is folded into the final BUSY step so hi_o/lo_o are already
  // corrected and registered on the first DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      dvs_q          <= '0;
      qneg_q         <= 1'b0;
      rneg_q         <= 1'b0;
      hi_o           <= '0;
      lo_o           <= '0;
      result_valid_o <= 1'b0;
    end else begin
      result_valid_o <= (state_nx == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            rem_q  <= '0;
            quo_q  <= mag_a;
            dvs_q  <= mag_b;
            qneg_q <= qneg_in;
            rneg_q <= rneg_in;
            cnt    <= CNT_W'(WIDTH);
`ifdef DIV_ZERO_FAST_EN
            if (opb_i == '0) begin
              cnt  <= '0;
              lo_o <= qneg_in ? WIDTH'(1) : '1;
              hi_o <= rneg_in ? -mag_a : mag_a;
            end
`endif
          end
        end
        BUSY: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt - CNT_W'(1);
          if (state_nx == DONE) begin
            lo_o <= qneg_q ? -quo_nx : quo_nx;
            hi_o <= rneg_q ? -rem_nx : rem_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit against an arithmetic reference model.
module tb_div_iter_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             div_valid_i;
  logic             signed_i;
  logic [WIDTH-1:0] opa_i;
  logic [WIDTH-1:0] opb_i;
  logic             flush_i;
  logic             hold_i;
  logic [1:0]       hilowrite_i;
  logic             stall_o;
  logic             result_valid_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic [1:0]       hilowrite_o;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  div_iter_unit #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .div_valid_i    (div_valid_i),
    .signed_i       (signed_i),
    .opa_i          (opa_i),
    .opb_i          (opb_i),
    .flush_i        (flush_i),
    .hold_i         (hold_i),
    .hilowrite_i    (hilowrite_i),
    .stall_o        (stall_o),
    .result_valid_o (result_valid_o),
    .hi_o           (hi_o),
    .lo_o           (lo_o),
    .hilowrite_o    (hilowrite_o)
  );

  // Reference: integer division truncating toward zero; x/0 gives all-ones
  // magnitude and the dividend's magnitude, then the usual sign rules.
  function automatic void ref_div(input logic sgn, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b,
                                  output logic [WIDTH-1:0] q,
                                  output logic [WIDTH-1:0] r);
    longint sa, sb, qq, rr, ones;
    ones = (longint'(1) <<< WIDTH) - 1;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    if (sb == 0) begin
      qq = (sa < 0) ? -ones : ones;
      rr = sa;
    end else begin
      qq = sa / sb;
      rr = sa % sb;
    end
    q = qq[WIDTH-1:0];
    r = rr[WIDTH-1:0];
  endfunction

  function automatic int exp_lat(input logic [WIDTH-1:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == '0) ? 1 : WIDTH + 1;
`else
    return WIDTH + 1;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return WIDTH'($urandom_range(1, 15));
      2:       return {1'b1, {(WIDTH-1){1'b0}}};
      3:       return '1;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  // Issues one request and waits (bounded) for result_valid_o; reports latency
  // in cycles from acceptance and whether stall/HI-LO gating held throughout.
  task automatic run_div(input logic sgn, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, output int lat,
                         output logic stall_ok, output logic hilo_ok);
    @(negedge clk);
    div_valid_i = 1'b1;
    signed_i    = sgn;
    opa_i       = a;
    opb_i       = b;
    #1;
    stall_ok = (stall_o === 1'b1);
    hilo_ok  = (hilowrite_o === 2'b00);
    @(posedge clk);
    @(negedge clk);
    div_valid_i = 1'b0;
    lat = 1;
    while (result_valid_o !== 1'b1 && lat < 100) begin
      if (stall_o !== 1'b1)      stall_ok = 1'b0;
      if (hilowrite_o !== 2'b00) hilo_ok  = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; div_valid_i = 1'b0; signed_i = 1'b0; opa_i = '0; opb_i = '0;
    flush_i = 1'b0; hold_i = 1'b0; hilowrite_i = 2'b10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall_o); else passed++;
    total++; if (result_valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", result_valid_o); else passed++;
    total++; if (hi_o !== '0 || lo_o !== '0) $display("FAIL reset_hilo: got hi=%h lo=%h expected 0/0", hi_o, lo_o); else passed++;
    total++; if (hilowrite_o !== 2'b10) $display("FAIL reset_hilowrite: got %b expected 10", hilowrite_o); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_unsigned_basic();
    int lat; logic s_ok, h_ok;
    hilowrite_i = 2'b01;
    run_div(1'b0, 100, 7, lat, s_ok, h_ok);
    total++; if (lat != WIDTH + 1) $display("FAIL basic_latency: got %0d expected %0d", lat, WIDTH + 1); else passed++;
    total++; if (!s_ok) $display("FAIL basic_stall_busy: got stall drop expected stall held"); else passed++;
    total++; if (!h_ok) $display("FAIL basic_hilo_gated: got write during stall expected 00"); else passed++;
    total++; if (lo_o !== 32'd14 || hi_o !== 32'd2) $display("FAIL basic_result: got lo=%0d hi=%0d expected 14/2", lo_o, hi_o); else passed++;
    total++; if (hilowrite_o !== 2'b11 || stall_o !== 1'b0) $display("FAIL basic_done_ctrl: got hw=%b stall=%b expected 11/0", hilowrite_o, stall_o); else passed++;
  endtask

  task automatic test_signed();
    int lat; logic s_ok, h_ok; logic [WIDTH-1:0] eq, er;
    logic [WIDTH-1:0] av [3] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7};
    logic [WIDTH-1:0] bv [3] = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    for (int i = 0; i < 3; i++) begin
      ref_div(1'b1, av[i], bv[i], eq, er);
      run_div(1'b1, av[i], bv[i], lat, s_ok, h_ok);
      total++; if (lo_o !== eq || hi_o !== er || lat != WIDTH + 1)
        $display("FAIL signed_%0d: got lo=%h hi=%h lat=%0d expected lo=%h hi=%h lat=%0d", i, lo_o, hi_o, lat, eq, er, WIDTH + 1);
      else passed++;
    end
  endtask

  task automatic test_div_zero();
    int lat; logic s_ok, h_ok; logic [WIDTH-1:0] eq, er;
    run_div(1'b0, 5, 0, lat, s_ok, h_ok);
    total++; if (lo_o !== 32'hFFFF_FFFF || hi_o !== 32'd5) $display("FAIL divzero_unsigned: got lo=%h hi=%h expected ffffffff/5", lo_o, hi_o); else passed++;
    total++; if (lat != exp_lat('0)) $display("FAIL divzero_latency: got %0d expected %0d", lat, exp_lat('0)); else passed++;
    ref_div(1'b1, 32'hFFFF_FFF9, 0, eq, er);
    run_div(1'b1, 32'hFFFF_FFF9, 0, lat, s_ok, h_ok);
    total++; if (lo_o !== eq || hi_o !== er || lat != exp_lat('0))
      $display("FAIL divzero_signed: got lo=%h hi=%h lat=%0d expected lo=%h hi=%h lat=%0d", lo_o, hi_o, lat, eq, er, exp_lat('0));
    else passed++;
  endtask

  task automatic test_random();
    int lat; logic s_ok, h_ok; logic sgn; logic [WIDTH-1:0] a, b, eq, er;
    for (int i = 0; i < 16; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = pick_operand();
      b = pick_operand();
      ref_div(sgn, a, b, eq, er);
      hilowrite_i = 2'($urandom_range(0, 2));
      run_div(sgn, a, b, lat, s_ok, h_ok);
      total++; if (lo_o !== eq || hi_o !== er || lat != exp_lat(b) || !s_ok || !h_ok || hilowrite_o !== 2'b11)
        $display("FAIL random_%0d: sgn=%b a=%h b=%h got lo=%h hi=%h lat=%0d stall_ok=%b hilo_ok=%b hw=%b expected lo=%h hi=%h lat=%0d hw=11",
                 i, sgn, a, b, lo_o, hi_o, lat, s_ok, h_ok, hilowrite_o, eq, er, exp_lat(b));
      else passed++;
    end
  endtask

  task automatic test_flush();
    logic [WIDTH-1:0] hi_prev, lo_prev; logic bad;
    hilowrite_i = 2'b00;
    @(negedge clk);
    hi_prev = hi_o; lo_prev = lo_o;
    div_valid_i = 1'b1; signed_i = 1'b0; opa_i = 32'd1234567; opb_i = 32'd89;
    @(posedge clk);
    @(negedge clk);
    div_valid_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    #1;
    total++; if (hilowrite_o === 2'b11) $display("FAIL flush_busy_hw: got %b expected not 11", hilowrite_o); else passed++;
    @(posedge clk);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    total++; if (stall_o !== 1'b0 || result_valid_o !== 1'b0) $display("FAIL flush_idle: got stall=%b valid=%b expected 0/0", stall_o, result_valid_o); else passed++;
    total++; if (hi_o !== hi_prev || lo_o !== lo_prev) $display("FAIL flush_hold_results: got hi=%h lo=%h expected hi=%h lo=%h", hi_o, lo_o, hi_prev, lo_prev); else passed++;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hilowrite_o === 2'b11 || result_valid_o !== 1'b0 || stall_o !== 1'b0) bad = 1'b1;
    end
    total++; if (bad) $display("FAIL flush_no_write: got late write/valid/stall expected none"); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat, vcycles; logic s_ok, h_ok, stable;
    logic [WIDTH-1:0] hq, lq;
    hilowrite_i = 2'b01;
    run_div(1'b0, 1000, 33, lat, s_ok, h_ok);
    hold_i = 1'b1;
    hq = hi_o; lq = lo_o;
    total++; if (lq !== 32'd30 || hq !== 32'd10) $display("FAIL hold_result: got lo=%0d hi=%0d expected 30/10", lq, hq); else passed++;
    vcycles = 1; stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (result_valid_o === 1'b1 && hilowrite_o === 2'b11) vcycles++;
      if (hi_o !== hq || lo_o !== lq || stall_o !== 1'b0) stable = 1'b0;
    end
    hold_i = 1'b0;
    total++; if (vcycles != 4) $display("FAIL hold_valid_cycles: got %0d expected 4", vcycles); else passed++;
    total++; if (!stable) $display("FAIL hold_stable: got results/stall changed expected stable"); else passed++;
    run_div(1'b0, 9, 3, lat, s_ok, h_ok);
    total++; if (lo_o !== 32'd3 || hi_o !== 32'd0 || lat != WIDTH + 1 || !s_ok)
      $display("FAIL back_to_back: got lo=%0d hi=%0d lat=%0d stall_ok=%b expected 3/0/%0d/1", lo_o, hi_o, lat, s_ok, WIDTH + 1);
    else passed++;
  endtask

  task automatic test_passthrough();
    logic [1:0] hw;
    @(negedge clk);
    div_valid_i = 1'b0;
    hilowrite_i = 2'b01;
    #1;
    total++; if (hilowrite_o !== 2'b01 || stall_o !== 1'b0) $display("FAIL passthru_01: got hw=%b stall=%b expected 01/0", hilowrite_o, stall_o); else passed++;
    for (int i = 0; i < 4; i++) begin
      hw = 2'($urandom_range(0, 3));
      @(negedge clk);
      hilowrite_i = hw;
      #1;
      total++; if (hilowrite_o !== hw) $display("FAIL passthru_rand_%0d: got %b expected %b", i, hilowrite_o, hw); else passed++;
    end
  endtask

  task automatic test_reset_mid_busy();
    int lat; logic s_ok, h_ok;
    hilowrite_i = 2'b00;
    @(negedge clk);
    div_valid_i = 1'b1; signed_i = 1'b0; opa_i = 32'd77777; opb_i = 32'd5;
    @(posedge clk);
    @(negedge clk);
    div_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    hilowrite_i = 2'b10;
    @(posedge clk);
    @(negedge clk);
    total++; if (stall_o !== 1'b0 || result_valid_o !== 1'b0 || hi_o !== '0 || lo_o !== '0 || hilowrite_o !== 2'b10)
      $display("FAIL reset_mid_busy: got stall=%b valid=%b hi=%h lo=%h hw=%b expected 0/0/0/0/10", stall_o, result_valid_o, hi_o, lo_o, hilowrite_o);
    else passed++;
    rst = 1'b0;
    run_div(1'b0, 50, 6, lat, s_ok, h_ok);
    total++; if (lo_o !== 32'd8 || hi_o !== 32'd2 || lat != WIDTH + 1) $display("FAIL post_reset_div: got lo=%0d hi=%0d lat=%0d expected 8/2/%0d", lo_o, hi_o, lat, WIDTH + 1); else passed++;
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_zero();
    test_random();
    test_flush();
    test_back_to_back();
    test_passthrough();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Parametrised multi-cycle integer divider with its own pipeline handshake, replacing the combinational div start/HI-LO-write decode in the EX stage.
- Accepts a DIV/DIVU request from EX and stalls the pipeline while it iterates.
- Produces quotient (LO) and remainder (HI), and generates the HI/LO write enables, passing through the non-divide enables unchanged.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits (>=4).
- CNT_W, $clog2(WIDTH+1), iteration-counter width (derived localparam, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- div_valid_i  in  1  EX holds a DIV/DIVU instruction
- signed_i  in  1  1=DIV (signed), 0=DIVU
- opa_i  in  WIDTH  dividend
- opb_i  in  WIDTH  divisor
- flush_i  in  1  exception/branch flush of EX; cancels operation
- hold_i  in  1  pipeline held by another stall source (e.g. memory)
- hilowrite_i  in  2  decoder HI/LO write enables {hi,lo} for non-divide ops
- stall_o  out  1  freeze IF/ID/EX
- result_valid_o  out  1  quotient/remainder valid
- hi_o  out  WIDTH  remainder
- lo_o  out  WIDTH  quotient
- hilowrite_o  out  2  final HI/LO write enables

Behaviour:
- Reset: state=IDLE, counter=0, hi_o=lo_o=0, result_valid_o=0; stall_o=0 and hilowrite_o=hilowrite_i (combinational).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - div_valid_i && !flush_i: latch |opa|, |opb| (magnitudes when signed_i=1, raw otherwise), sign of quotient (opa MSB ^ opb MSB) and sign of remainder (opa MSB); counter=WIDTH; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY: one restoring step per cycle.
  - Shift {rem,quo} left 1 and trial-subtract the divisor (WIDTH+1 bits).
  - If non-negative, keep the difference and set quotient LSB=1.
  - Decrement counter; on the cycle the counter reaches 0, go to DONE.
- DONE:
  - Apply sign fix-up to the registered results: negate quotient if its sign bit is set, negate remainder if dividend was negative.
  - result_valid_o=1.
  - Stay in DONE while hold_i=1 (results stable); otherwise go to IDLE next cycle.
- Latency: a request accepted at cycle t gives result_valid_o=1 at t+WIDTH+1.
- stall_o (combinational) = (IDLE && div_valid_i && !flush_i) || BUSY. It is 0 in DONE.
- hilowrite_o (combinational):
  - 2'b11 in DONE;
  - 2'b00 when stall_o=1;
  - hilowrite_i otherwise.
- flush_i:
  - In BUSY or DONE: return to IDLE next cycle, result_valid_o=0, no HI/LO write.
  - In IDLE: the request is ignored.
  - flush_i overrides hold_i.
- Back-to-back divides: DONE→IDLE, and the next instruction's div_valid_i is accepted in that IDLE cycle. There is no DONE→BUSY shortcut.
- Divide by zero (arithmetic-defined, no trap):
  - unsigned: quotient = all ones, remainder = dividend;
  - signed: the same raw magnitudes, then sign fix-up is applied.
- Most-negative / -1: quotient = most-negative value (wraps), remainder=0.
- hi_o/lo_o hold their last values outside DONE.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined: opb_i==0 at acceptance goes IDLE→DONE directly (latency 1), loading the divide-by-zero results listed above.
- Undefined: divide by zero runs the full WIDTH iterations. Results are bit-identical either way; only latency differs.

Decomposition:
- Shared package/header (div_pkg or defines.vh): state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10) and HI/LO write-enable constants HILO_NONE=2'b00, HILO_BOTH=2'b11.
- One natural sub-module: div_step, a combinational single restoring iteration taking rem, quo and divisor and returning next rem and quo. It is instantiated once inside the BUSY datapath.

Test Plan:
- Unsigned 100/7, WIDTH=32: stall_o high for cycles t..t+32; at t+33 lo_o=14, hi_o=2, hilowrite_o=11, stall_o=0.
- Signed -7/2: lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1). Signed 0x80000000/-1: lo_o=0x80000000, hi_o=0.
- Divide by zero, 5/0 unsigned: lo_o=0xFFFFFFFF, hi_o=5. Latency is 33 cycles without DIV_ZERO_FAST_EN and 1 cycle with it.
- flush_i pulsed at BUSY cycle 10: state IDLE next cycle, stall_o=0, hilowrite_o never 11, hi_o/lo_o unchanged.
- hold_i=1 for 3 cycles at DONE: result_valid_o and hilowrite_o=11 stay for 4 cycles total with results stable. Then back-to-back DIVU 9/3 gives lo_o=3, hi_o=0.
- Non-div instruction with hilowrite_i=01, div_valid_i=0: hilowrite_o=01 and stall_o=0 in the same cycle. Reset asserted mid-BUSY: all outputs at reset values the next cycle.
